operand_accumulator: RTL and testbench

Parametrised operand collector between the fetch/decode stage and the ALU. Captures up to DEPTH operands of WIDTH bits in arrival order on put instructions. On op instructions it releases the oldest op_need operands and shifts the survivors down. All state is registered, with per-instruction gating on the control counter, full/empty/ready status and sticky overflow/underflow error flags.

---
 rtl/operand_accumulator.sv | 111 +++++++++++
 tb/tb_operand_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_accumulator.sv
// Operand collector between fetch/decode and the ALU: appends operands in arrival
// order and releases the oldest ones on op instructions, acting once per control_ctr value.
module operand_accumulator #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CTR_W = 12,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   put_en,
    input  logic                   op_en,
    input  logic [WIDTH-1:0]       value,
    input  logic [CNT_W-1:0]       op_need,
    input  logic [CTR_W-1:0]       control_ctr,
    input  logic                   clr_err,
    output logic [DEPTH*WIDTH-1:0] operands,
    output logic [DEPTH-1:0]       slot_valid,
    output logic [CNT_W-1:0]       count,
    output logic                   empty,
    output logic                   full,
    output logic                   ready,
    output logic                   overflow,
    output logic                   underflow,
    output logic [CTR_W-1:0]       accumulator_ctr
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH*WIDTH-1:0] slots_q, slots_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CTR_W-1:0]       ctr_q;
    logic [CTR_W-1:0]       acc_ctr_q, acc_ctr_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;
    logic                   is_event;

    // An instruction acts only on the cycle its counter value first appears, so a
    // stalled instruction held for several cycles is applied exactly once.
    always_comb begin
        is_event  = (control_ctr != ctr_q);
        slots_d   = slots_q;
        count_d   = count_q;
        acc_ctr_d = acc_ctr_q;
        ovf_d     = ovf_q & ~clr_err;
        udf_d     = udf_q & ~clr_err;

        if (is_event) begin
            acc_ctr_d = control_ctr;
            if (op_en) begin
                if (op_need == '0) begin
                    count_d = '0;
                end else if (op_need <= count_q) begin
                    slots_d = slots_q >> (int'(op_need) * WIDTH);
                    count_d = count_q - op_need;
                end else begin
                    count_d = '0;
                    udf_d   = 1'b1;
                end
            end
            // The put lands on the post-op contents, so a combined op+put never overflows.
            if (put_en) begin
                if (count_d < DEPTH_C) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (count_d == CNT_W'(i)) begin
                            slots_d[i*WIDTH +: WIDTH] = value;
                        end
                    end
                    count_d = count_d + CNT_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q   <= '0;
            count_q   <= '0;
            ctr_q     <= '1;
            acc_ctr_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            slots_q   <= slots_d;
            count_q   <= count_d;
            ctr_q     <= control_ctr;
            acc_ctr_q <= acc_ctr_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    assign operands        = slots_q;
    assign count           = count_q;
    assign empty           = (count_q == '0);
    assign full            = (count_q == DEPTH_C);
    assign ready           = (count_q >= op_need) && (op_need != '0);
    assign overflow        = ovf_q;
    assign underflow       = udf_q;
    assign accumulator_ctr = acc_ctr_q;

endmodule

// File: tb/tb_operand_accumulator.sv
// Bench for operand_accumulator: directed scenarios followed by random instructions,
// checked against a queue-based reference model.
module tb_operand_accumulator;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CTR_W = 12;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clk;
  logic                   rst_n;
  logic                   put_en;
  logic                   op_en;
  logic [WIDTH-1:0]       value;
  logic [CNT_W-1:0]       op_need;
  logic [CTR_W-1:0]       control_ctr;
  logic                   clr_err;
  logic [DEPTH*WIDTH-1:0] operands;
  logic [DEPTH-1:0]       slot_valid;
  logic [CNT_W-1:0]       count;
  logic                   empty;
  logic                   full;
  logic                   ready;
  logic                   overflow;
  logic                   underflow;
  logic [CTR_W-1:0]       accumulator_ctr;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf;
  logic             m_udf;
  logic [CTR_W-1:0] m_acc;
  logic [CTR_W-1:0] m_last_ctr;

  operand_accumulator #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CTR_W(CTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .put_en(put_en), .op_en(op_en), .value(value),
    .op_need(op_need), .control_ctr(control_ctr), .clr_err(clr_err),
    .operands(operands), .slot_valid(slot_valid), .count(count), .empty(empty),
    .full(full), .ready(ready), .overflow(overflow), .underflow(underflow),
    .accumulator_ctr(accumulator_ctr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_acc = '0;
    m_last_ctr = '1;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [DEPTH-1:0] exp_sv;
    n = exp_q.size();
    exp_sv = '0;
    for (int i = 0; i < DEPTH; i++) exp_sv[i] = (i < n);
    chk("count", 64'(count), 64'(n));
    chk("slot_valid", 64'(slot_valid), 64'(exp_sv));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("ready", 64'(ready), 64'((n >= int'(op_need)) && (op_need != 0)));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_udf));
    chk("accumulator_ctr", 64'(accumulator_ctr), 64'(m_acc));
    for (int k = 0; k < n; k++)
      chk($sformatf("slot%0d", k), 64'(operands[k*WIDTH +: WIDTH]), 64'(exp_q[k]));
  endtask

  // Applies the instruction rules to the model for the edge just taken.
  task automatic model_step();
    logic new_o;
    logic new_u;
    new_o = 1'b0;
    new_u = 1'b0;
    if (control_ctr != m_last_ctr) begin
      m_acc = control_ctr;
      if (op_en) begin
        if (op_need == 0) exp_q.delete();
        else if (int'(op_need) <= exp_q.size()) begin
          for (int i = 0; i < int'(op_need); i++) void'(exp_q.pop_front());
        end else begin
          exp_q.delete();
          new_u = 1'b1;
        end
      end
      if (put_en) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(value);
        else new_o = 1'b1;
      end
    end
    m_last_ctr = control_ctr;
    m_ovf = (m_ovf && !clr_err) || new_o;
    m_udf = (m_udf && !clr_err) || new_u;
  endtask

  // driver
  task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] v,
                      input logic [CNT_W-1:0] need, input logic [CTR_W-1:0] ctr,
                      input logic clr);
    put_en = p;
    op_en = o;
    value = v;
    op_need = need;
    control_ctr = ctr;
    clr_err = clr;
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    put_en = 1'b0;
    op_en = 1'b0;
    value = '0;
    op_need = '0;
    control_ctr = '1;
    clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CTR_W-1:0] ctr_cur;
    do_reset();
    check_all();
    chk("reset_operands", 64'(operands), 64'd0);

    // fill and overflow
    step(1, 0, 8'd5, 0, 12'd1, 0);
    step(1, 0, 8'd9, 0, 12'd2, 0);
    step(1, 0, 8'd12, 0, 12'd3, 0);
    chk("fill_operands", 64'(operands), 64'h0C0905);
    step(1, 0, 8'd7, 0, 12'd4, 0);

    // gating: one put held for four cycles
    step(0, 1, 8'd0, 0, 12'd5, 1);
    repeat (4) step(1, 0, 8'd5, 0, 12'd10, 0);

    // partial consume, then clear-all
    step(0, 1, 8'd0, 0, 12'd11, 0);
    step(1, 0, 8'd5, 0, 12'd12, 0);
    step(1, 0, 8'd9, 0, 12'd13, 0);
    step(1, 0, 8'd12, 0, 12'd14, 0);
    step(0, 1, 8'd0, 2, 12'd15, 0);
    step(0, 0, 8'd0, 2, 12'd15, 0);
    step(0, 1, 8'd0, 0, 12'd16, 0);

    // simultaneous op and put on a full collector
    step(1, 0, 8'd1, 0, 12'd17, 0);
    step(1, 0, 8'd2, 0, 12'd18, 0);
    step(1, 0, 8'd3, 0, 12'd19, 0);
    step(1, 1, 8'd4, 1, 12'd20, 0);
    chk("simul_operands", 64'(operands), 64'h040302);

    // underflow, then clear racing a new overflow
    step(0, 1, 8'd0, 2, 12'd21, 0);
    step(0, 1, 8'd0, 3, 12'd22, 0);
    step(1, 0, 8'd6, 0, 12'd23, 0);
    step(1, 0, 8'd7, 0, 12'd24, 0);
    step(1, 0, 8'd8, 0, 12'd25, 0);
    step(1, 0, 8'd9, 0, 12'd26, 1);
    step(0, 0, 8'd0, 0, 12'd26, 1);

    // asynchronous reset between edges with two operands held
    step(0, 1, 8'd0, 0, 12'd27, 0);
    step(1, 0, 8'hA1, 0, 12'd28, 0);
    step(1, 0, 8'hA2, 0, 12'd29, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 8'h33, 0, 12'hFFF, 0);
    step(1, 0, 8'h44, 0, 12'h000, 0);

    // random instruction stream, starting near the counter wrap
    ctr_cur = 12'hFF0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: ;
        1, 2: ctr_cur = ctr_cur + 1'b1;
        default: ctr_cur = CTR_W'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
           CNT_W'($urandom_range(0, 3)), ctr_cur, ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
